// File: rtl/gray_bcd_display.sv
// Gray-coded switch input -> synchronised binary LEDs -> sequential double-dabble BCD ->
// time-multiplexed 7-segment display with leading-zero blanking.
module gray_bcd_display #(
  parameter int WIDTH   = 4,
  parameter int DIGITS  = 2,
  parameter int MUX_DIV = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [WIDTH-1:0]      gray_i,
  output logic [WIDTH-1:0]      led,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  busy,
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     an
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH);
  localparam int DW = (MUX_DIV > 1) ? $clog2(MUX_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  function automatic int dec_digits(input int w);
    int v;
    int n;
    v = (1 << w) - 1;
    n = 1;
    while (v >= 10) begin
      v = v / 10;
      n++;
    end
    return n;
  endfunction

  if (WIDTH < 2 || WIDTH > 16) begin : g_bad_width
    $error("gray_bcd_display: WIDTH must be 2..16");
  end
  if (DIGITS < dec_digits(WIDTH)) begin : g_bad_digits
    $error("gray_bcd_display: DIGITS too small for 2^WIDTH-1");
  end
  if (MUX_DIV < 1) begin : g_bad_div
    $error("gray_bcd_display: MUX_DIV must be at least 1");
  end

  function automatic logic [6:0] seven(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1111110;
      4'd1:    return 7'b0110000;
      4'd2:    return 7'b1101101;
      4'd3:    return 7'b1111001;
      4'd4:    return 7'b0110011;
      4'd5:    return 7'b1011011;
      4'd6:    return 7'b1011111;
      4'd7:    return 7'b1110000;
      4'd8:    return 7'b1111111;
      4'd9:    return 7'b1111011;
      default: return 7'b0000000;
    endcase
  endfunction

  // ---------------- input path ----------------
  logic [WIDTH-1:0] sync1, sync2, bin_d, bin_q;

  always_comb begin
    bin_d = '0;
    for (int i = 0; i < WIDTH; i++) bin_d[i] = ^(sync2 >> i);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      bin_q <= '0;
    end else begin
      sync1 <= gray_i;
      sync2 <= sync1;
      bin_q <= bin_d;
    end
  end

  assign led = bin_q;

  // ---------------- conversion FSM ----------------
  typedef enum logic {IDLE, CONV} state_t;
  state_t            state_q, state_d;
  logic [WIDTH-1:0]  src_q, src_d, shift_q, shift_d, step_shift;
  logic [BW-1:0]     scratch_q, scratch_d, adj, step_bcd, bcd_q, bcd_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      src_q     <= '0;
      shift_q   <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      bcd_q     <= '0;
    end else begin
      state_q   <= state_d;
      src_q     <= src_d;
      shift_q   <= shift_d;
      scratch_q <= scratch_d;
      cnt_q     <= cnt_d;
      bcd_q     <= bcd_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    shift_d   = shift_q;
    scratch_d = scratch_q;
    cnt_d     = cnt_q;
    bcd_d     = bcd_q;
    busy      = 1'b0;
    adj       = scratch_q;
    for (int k = 0; k < DIGITS; k++)
      if (adj[4*k +: 4] >= 4'd5) adj[4*k +: 4] = adj[4*k +: 4] + 4'd3;
    step_bcd   = {adj[BW-2:0], shift_q[WIDTH-1]};
    step_shift = {shift_q[WIDTH-2:0], 1'b0};
    case (state_q)
      IDLE: begin
        if (bin_q != src_q) begin
          src_d     = bin_q;
          shift_d   = bin_q;
          scratch_d = '0;
          cnt_d     = '0;
          state_d   = CONV;
        end
      end
      CONV: begin
        busy      = 1'b1;
        scratch_d = step_bcd;
        shift_d   = step_shift;
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          bcd_d   = step_bcd;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bcd = bcd_q;

  // ---------------- display multiplexer ----------------
  logic [DW-1:0]     div_q, div_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [6:0]        seg_q;
  logic [DIGITS-1:0] zero_above;
  logic [3:0]        nib;
  logic              blank, wrap;

  // seg is registered against the index about to be shown so it stays aligned with an
  always_comb begin
    wrap  = (div_q == DW'(MUX_DIV - 1));
    div_d = wrap ? '0 : div_q + 1'b1;
    idx_d = idx_q;
    if (wrap) idx_d = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
    zero_above = '0;
    for (int k = 0; k < DIGITS; k++) zero_above[k] = ((bcd_q >> (4*k)) == '0);
    nib   = bcd_q[{idx_d, 2'b00} +: 4];
    blank = (idx_d != '0) && zero_above[idx_d];
    an    = '1;
    an[idx_q] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= '0;
      idx_q <= '0;
      seg_q <= 7'b1111110;
    end else begin
      div_q <= div_d;
      idx_q <= idx_d;
      seg_q <= blank ? 7'b0000000 : seven(nib);
    end
  end

  assign seg = seg_q;

endmodule
